// File: rtl/week02_re02.sv
// Registered magnitude comparator: MSB-first bit-slice cascade feeding one-hot Eq/Gt/Lt flops.
// SIGNED=1 flips the sense of the MSB slice's greater-than term for two's-complement operands.

module week02_re02_slice #(
  parameter bit INV_GT = 1'b0
) (
  input  logic i_a,
  input  logic i_b,
  output logic o_e,
  output logic o_g
);
  assign o_e = ~(i_a ^ i_b);
  assign o_g = INV_GT ? (~i_a & i_b) : (i_a & ~i_b);
endmodule

module week02_re02 #(
  parameter int WIDTH  = 2,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Eq,
  output logic             Gt,
  output logic             Lt
);
  logic [WIDTH-1:0] w_e, w_g;
  logic [WIDTH:0]   w_gt_acc, w_eq_acc;
  logic             w_gt, w_eq, w_lt;
  logic             r_eq, r_gt, r_lt;

  // Only the MSB slice is sign-aware; lower bits always compare as magnitudes.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    week02_re02_slice #(
      .INV_GT ((i == WIDTH-1) && SIGNED)
    ) u_slice (
      .i_a (A[i]),
      .i_b (B[i]),
      .o_e (w_e[i]),
      .o_g (w_g[i])
    );
  end

  // Ripple from the MSB: a lower slice can only decide gt if every slice above it is equal.
  assign w_gt_acc[WIDTH] = 1'b0;
  assign w_eq_acc[WIDTH] = 1'b1;
  for (genvar i = WIDTH-1; i >= 0; i--) begin : g_cascade
    assign w_gt_acc[i] = w_gt_acc[i+1] | (w_eq_acc[i+1] & w_g[i]);
    assign w_eq_acc[i] = w_eq_acc[i+1] & w_e[i];
  end

  assign w_gt = w_gt_acc[0];
  assign w_eq = w_eq_acc[0];
  assign w_lt = ~w_gt & ~w_eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eq <= 1'b0;
      r_gt <= 1'b0;
      r_lt <= 1'b0;
    end else begin
      r_eq <= w_eq;
      r_gt <= w_gt;
      r_lt <= w_lt;
    end
  end

  assign Eq = r_eq;
  assign Gt = r_gt;
  assign Lt = r_lt;
endmodule

// File: tb/tb_week02_re02.sv
// Directed bench: unsigned and signed 2-bit comparators share operands; table sweep plus
// reset, latency and mid-stream reset sequences.

module tb_week02_re02;
  localparam logic [2:0] E = 3'b100, G = 3'b010, L = 3'b001, Z = 3'b000;

  logic       clk, rst_n;
  logic [1:0] A, B;
  logic       u_eq, u_gt, u_lt, s_eq, s_gt, s_lt;
  int         n_chk, n_fail;

  week02_re02 #(.WIDTH(2), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Eq(u_eq), .Gt(u_gt), .Lt(u_lt)
  );
  week02_re02 #(.WIDTH(2), .SIGNED(1'b1)) s_dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Eq(s_eq), .Gt(s_gt), .Lt(s_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] exp_u;
    logic [2:0] exp_s;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {Eq,Gt,Lt}=%b expected %b (A=%0d B=%0d)", nm, act, exp, A, B);
    end
  endtask

  task automatic chk_onehot(input string nm, input logic [2:0] act);
    n_chk++;
    if ($countones(act) != 1) begin
      n_fail++;
      $display("FAIL %s: got {Eq,Gt,Lt}=%b expected exactly one flag set", nm, act);
    end
  endtask

  function automatic logic [2:0] uf();
    return {u_eq, u_gt, u_lt};
  endfunction
  function automatic logic [2:0] sf();
    return {s_eq, s_gt, s_lt};
  endfunction

  initial begin
    n_chk = 0; n_fail = 0;
    tbl[0]  = '{2'd0, 2'd0, E, E};
    tbl[1]  = '{2'd0, 2'd1, L, L};
    tbl[2]  = '{2'd0, 2'd2, L, G};
    tbl[3]  = '{2'd0, 2'd3, L, G};
    tbl[4]  = '{2'd1, 2'd0, G, G};
    tbl[5]  = '{2'd1, 2'd1, E, E};
    tbl[6]  = '{2'd1, 2'd2, L, G};
    tbl[7]  = '{2'd1, 2'd3, L, G};
    tbl[8]  = '{2'd2, 2'd0, G, L};
    tbl[9]  = '{2'd2, 2'd1, G, L};
    tbl[10] = '{2'd2, 2'd2, E, E};
    tbl[11] = '{2'd2, 2'd3, L, L};
    tbl[12] = '{2'd3, 2'd0, G, L};
    tbl[13] = '{2'd3, 2'd1, G, L};
    tbl[14] = '{2'd3, 2'd2, G, G};
    tbl[15] = '{2'd3, 2'd3, E, E};

    // Reset held with A>B: flags clear immediately and stay clear across edges.
    rst_n = 1'b0; A = 2'd2; B = 2'd1;
    #1;
    chk("reset_immediate", uf(), Z);
    chk("reset_immediate_s", sf(), Z);
    @(posedge clk); #1;
    chk("reset_edge", uf(), Z);
    @(posedge clk); #1;
    chk("reset_edge2", uf(), Z);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("reset_release_pre_edge", uf(), Z);
    @(posedge clk); #1;
    chk("reset_release_gt", uf(), G);

    // Exhaustive sweep, each pair held for two edges.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      A = tbl[i].a; B = tbl[i].b;
      for (int k = 0; k < 2; k++) begin
        @(posedge clk); #1;
        chk($sformatf("sweep_u[%0d]", i), uf(), tbl[i].exp_u);
        chk($sformatf("sweep_s[%0d]", i), sf(), tbl[i].exp_s);
        chk_onehot($sformatf("onehot_u[%0d]", i), uf());
        chk_onehot($sformatf("onehot_s[%0d]", i), sf());
      end
    end

    // Latency: A goes 0->3 with B=1 between edges; old result holds until the next edge.
    @(negedge clk); A = 2'd0; B = 2'd1;
    @(posedge clk); #1;
    chk("lat_before", uf(), L);
    @(negedge clk); A = 2'd3;
    #1 chk("lat_mid_cycle", uf(), L);
    #3 chk("lat_just_before_edge", uf(), L);
    @(posedge clk); #1;
    chk("lat_after_edge", uf(), G);
    chk("lat_after_edge_s", sf(), L);

    // Extremes.
    @(negedge clk); A = 2'd3; B = 2'd0;
    @(posedge clk); #1;
    chk("ext_max_min", uf(), G);
    chk_onehot("ext_max_min_oh", uf());
    @(negedge clk); A = 2'd0; B = 2'd3;
    @(posedge clk); #1;
    chk("ext_min_max", uf(), L);
    chk_onehot("ext_min_max_oh", uf());

    // Mid-stream reset while Gt=1, asserted between edges.
    @(negedge clk); A = 2'd2; B = 2'd1;
    @(posedge clk); #1;
    chk("mid_pre_gt", uf(), G);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_immediate", uf(), Z);
    chk("mid_reset_immediate_s", sf(), Z);
    @(posedge clk); #1;
    chk("mid_reset_held", uf(), Z);
    @(negedge clk); rst_n = 1'b1; A = 2'd1; B = 2'd1;
    #1 chk("mid_release_pre_edge", uf(), Z);
    @(posedge clk); #1;
    chk("mid_release_eq", uf(), E);
    chk("mid_release_eq_s", sf(), E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
